// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter: one input bit per clock,
// BIN_W+1 cycles per conversion. Optional macro BIN2BCD_AUTO_REFRESH_EN makes it re-convert continuously.
module bin2bcd_seq #(
  parameter int BIN_W = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic [15:0]      bcd
);

  localparam logic [1:0]  S_IDLE  = 2'd0;
  localparam logic [1:0]  S_SHIFT = 2'd1;
  localparam logic [1:0]  S_DONE  = 2'd2;
  localparam logic [3:0]  LAST    = 4'(BIN_W - 1);
  localparam logic [15:0] MAX_DEC = 16'd9999;

  // Handshake: start is sampled on any edge where busy=0 (IDLE or DONE);
  // done is high for exactly one cycle, the cycle in which bcd/ovf first show the new result.
  logic [1:0]       state;
  logic [BIN_W-1:0] sreg;
  logic [15:0]      acc;
  logic [15:0]      acc_adj;
  logic [15:0]      acc_next;
  logic [3:0]       count;
  logic             ovf_pending;
  logic             go;
  logic [15:0]      bin_wide;

`ifdef BIN2BCD_AUTO_REFRESH_EN
  logic unused_start;
  assign unused_start = start;
  assign go = 1'b1;
`else
  assign go = start;
`endif

  assign bin_wide = 16'(bin);
  assign busy     = (state == S_SHIFT);
  assign done     = (state == S_DONE);

  // Add-3 on nibbles >= 5 keeps every digit in 0..9 after the following shift.
  always_comb begin
    acc_adj = acc;
    for (int i = 0; i < 4; i++) begin
      if (acc[4*i +: 4] >= 4'd5)
        acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    end
    acc_next = {acc_adj[14:0], sreg[BIN_W-1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      sreg        <= '0;
      acc         <= '0;
      count       <= '0;
      ovf_pending <= 1'b0;
      ovf         <= 1'b0;
      bcd         <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (go) begin
            sreg        <= bin;
            acc         <= '0;
            count       <= '0;
            ovf_pending <= (bin_wide > MAX_DEC);
            state       <= S_SHIFT;
          end else begin
            state <= S_IDLE;
          end
        end
        S_SHIFT: begin
          acc   <= acc_next;
          sreg  <= sreg << 1;
          count <= count + 4'd1;
          // Outputs are written only here so the display never sees partial sums.
          if (count == LAST) begin
            bcd   <= ovf_pending ? 16'h9999 : acc_next;
            ovf   <= ovf_pending;
            state <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: a transaction-level model (latched value, cycle countdown,
// decimal digit arithmetic) checked every cycle, plus directed literal expectations.
module tb_bin2bcd_seq;

  localparam int BIN_W = 14;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             start = 1'b0;
  logic [BIN_W-1:0] bin = '0;
  logic             busy;
  logic             done;
  logic             ovf;
  logic [15:0]      bcd;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int done_count = 0;
  int last_done_cyc = 0;

  // model state
  int          m_left = 0;
  int          m_val  = 0;
  logic        m_done = 1'b0;
  logic        m_ovf  = 1'b0;
  logic [15:0] m_bcd  = 16'h0000;

  bin2bcd_seq #(.BIN_W(BIN_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .ovf   (ovf),
    .bcd   (bcd)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    if (v > 9999) r = 16'h9999;
    else r = {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    return r;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // model: one conversion = capture, then BIN_W cycles busy, then one done cycle
  always @(posedge clk or negedge rst_n) begin
    logic start_eff;
`ifdef BIN2BCD_AUTO_REFRESH_EN
    start_eff = 1'b1;
`else
    start_eff = start;
`endif
    if (!rst_n) begin
      m_left = 0;
      m_done = 1'b0;
      m_ovf  = 1'b0;
      m_bcd  = 16'h0000;
    end else if (m_left > 0) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_done = 1'b1;
        m_bcd  = to_bcd(m_val);
        m_ovf  = (m_val > 9999);
      end
    end else begin
      m_done = 1'b0;
      if (start_eff) begin
        m_val  = int'(bin);
        m_left = BIN_W;
      end
    end
  end

  // compare process
  always @(negedge clk) begin
    check("busy", 16'(busy), 16'(m_left > 0));
    check("done", 16'(done), 16'(m_done));
    check("ovf",  16'(ovf),  16'(m_ovf));
    check("bcd",  bcd,       m_bcd);
    if (done) begin
      done_count++;
      last_done_cyc = cyc;
    end
  end

  // driver tasks
  task automatic pulse_start(input int v, output int edge0);
    @(posedge clk); #1;
    bin   = BIN_W'(v);
    start = 1'b1;
    @(posedge clk); #1;
    edge0 = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, output int at);
    bit seen = 0;
    at = -1;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        at = cyc;
      end
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s: done not seen within 40 cycles", name);
    end
  endtask

  task automatic convert(input int v, input string name);
    int e0, d;
    pulse_start(v, e0);
    wait_done(name, d);
    check({name, "_lat"}, 16'(d - e0), 16'(BIN_W));
    check({name, "_bcd"}, bcd, to_bcd(v));
    check({name, "_ovf"}, 16'(ovf), 16'(v > 9999));
  endtask

  initial begin
    int e0, d1, d2, dc;
    int vals[8] = '{9, 10, 99, 100, 999, 1000, 9998, 16383};
    // model pins
    check("model_1234", to_bcd(1234), 16'h1234);
    check("model_10000", to_bcd(10000), 16'h9999);
    check("model_42", to_bcd(42), 16'h0042);

    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_bcd", bcd, 16'h0000);
    check("rst_busy", 16'(busy), 16'h0);
    check("rst_done", 16'(done), 16'h0);
    @(posedge clk); #1 rst_n = 1'b1;

`ifdef BIN2BCD_AUTO_REFRESH_EN
    // rst_n was released with bin=0; resync with bin=300 through a fresh reset
    rst_n = 1'b0;
    bin = BIN_W'(300);
    @(posedge clk); #1 rst_n = 1'b1;
    wait_done("auto_first", d1);
    check("auto_bcd0", bcd, 16'h0300);
    @(posedge clk); #1 bin = BIN_W'(301);
    @(posedge clk); #1;
    @(posedge clk); #1;
    wait_done("auto_skip", d2);
    wait_done("auto_second", d2);
    check("auto_bcd1", bcd, 16'h0301);
    wait_done("auto_third", dc);
    check("auto_period", 16'(dc - d2), 16'(BIN_W + 1));
`else
    // 1234 single start, then back to idle
    convert(1234, "c1234");
    @(negedge clk);
    check("idle_after", 16'(busy | done), 16'h0);
    check("c1234_hold", bcd, 16'h1234);

    // back-to-back 0 then 9999 with start held through DONE
    @(posedge clk); #1;
    bin = '0; start = 1'b1;
    @(posedge clk); #1;
    bin = BIN_W'(9999);
    wait_done("b2b_0", d1);
    check("b2b_bcd0", bcd, 16'h0000);
    @(posedge clk); #1 start = 1'b0;
    wait_done("b2b_9999", d2);
    check("b2b_bcd1", bcd, 16'h9999);
    check("b2b_ovf", 16'(ovf), 16'h0);
    check("b2b_gap", 16'(d2 - d1), 16'(BIN_W + 1));

    // overflow then recovery
    convert(10000, "ovf10000");
    check("ovf_lit", {15'h0, ovf}, 16'h1);
    convert(42, "c42");
    check("c42_lit", bcd, 16'h0042);

    // start while busy is ignored
    pulse_start(5678, e0);
    repeat (4) @(posedge clk);
    #1 bin = BIN_W'(1111); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done("busy_start", d1);
    check("busy_start_bcd", bcd, 16'h5678);
    check("busy_start_lat", 16'(d1 - e0), 16'(BIN_W));

    // reset mid-conversion
    pulse_start(4321, e0);
    repeat (6) @(posedge clk);
    #3 rst_n = 1'b0;
    dc = done_count;
    @(negedge clk);
    check("abort_bcd", bcd, 16'h0000);
    check("abort_busy", 16'(busy), 16'h0);
    @(posedge clk); #3 rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1 check("abort_no_done", 16'(done_count), 16'(dc));
    convert(88, "c88");
    check("c88_lit", bcd, 16'h0088);

    // boundary sweep
    foreach (vals[i]) convert(vals[i], "sweep");
`endif

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Sequential binary-to-BCD converter using iterative double-dabble, one input bit per clock.
- Sits directly upstream of the 4-digit seven-segment driver and feeds its 16-bit digit bus with four BCD nibbles, so CPU values show in decimal.
- Holds the last result stable between conversions; start/busy/done handshake toward the CPU-side source.

Parameters:
- BIN_W, 14, binary input width; legal range 1..14; also the number of shift cycles per conversion.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request conversion of bin; sampled only when not busy
- bin  input  BIN_W  unsigned binary value to convert
- busy  output  1  conversion in progress
- done  output  1  one-cycle pulse; bcd and ovf updated this cycle
- ovf  output  1  last converted value exceeded 9999
- bcd  output  16  result: [15:12] thousands, [11:8] hundreds, [7:4] tens, [3:0] ones; connects to the display digit bus

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, busy=0, done=0, ovf=0, bcd=16'h0000, internal shift/count registers cleared. Display shows 0000.
- States:
  - IDLE: busy=0, done=0.
  - SHIFT: busy=1, done=0.
  - DONE: busy=0, done=1, lasts exactly one cycle.
- IDLE or DONE, start=1 at an edge: capture bin into the shift register, clear the 16-bit BCD accumulator, clear count, latch ovf_pending = (bin > 9999), go to SHIFT.
- DONE with start=0: go to IDLE. Back-to-back starts are legal, with no idle gap required.
- SHIFT, each edge:
  - Every accumulator nibble >= 5 gets +3.
  - Then {accumulator, shift register} shifts left by 1, MSB of bin first.
  - count increments.
- SHIFT, on the edge performing shift number BIN_W (count == BIN_W-1):
  - bcd <= final accumulator, or 16'h9999 if ovf_pending.
  - ovf <= ovf_pending.
  - Go to DONE.
- Latency: the start-sampling edge is edge 0. Shifts occur on edges 1..BIN_W. bcd, ovf and done change on edge BIN_W. A conversion occupies BIN_W+1 edges; latency is fixed and independent of the value.
- start while busy=1: ignored; no queueing, no effect on the current conversion.
- bin changes during SHIFT: no effect, because the value was captured at edge 0.
- bcd and ovf change only on the completion edge (or on reset) and never glitch through intermediate values. This is required because the display samples bcd continuously.
- Overflow can occur only when BIN_W=14 (inputs 10000..16383). For BIN_W <= 13 ovf stays 0.
- Reset mid-conversion: immediate abort to the reset values, with no done pulse. The next start begins a fresh conversion.
- Nibble correction uses 4-bit add with no carry out. Correction is applied only to nibbles >= 5, so no nibble ever exceeds 9 after a shift.

Optional Feature:
- Macro: BIN2BCD_AUTO_REFRESH_EN
- Defined: the block behaves as if start=1 in every IDLE and DONE cycle. The first conversion begins on the first edge after reset release, and bin is re-sampled after each completion. bcd tracks a live value with a refresh period of BIN_W+1 cycles, and done pulses every period. The start input is ignored.
- Not defined: conversions occur only on an explicit start, as described above.

Test Plan:
- BIN_W=14, bin=1234, start pulse for 1 cycle -> busy high for 14 cycles; done=1 in the cycle after edge 14; bcd=16'h1234; ovf=0; IDLE on the next edge.
- bin=0, then bin=9999 back-to-back, with start held through the DONE cycle -> bcd=16'h0000 then 16'h9999, done pulses 15 cycles apart, ovf=0 both times.
- bin=10000, start -> bcd=16'h9999, ovf=1. Follow with bin=42 -> bcd=16'h0042, ovf=0.
- bin=5678 start, then start with bin=1111 asserted at edge 5 -> bin=1111 ignored; result bcd=16'h5678 at edge 14.
- Conversion of 4321 followed by a rst_n pulse at edge 7 -> bcd=0, busy=0, done never pulses. A new start with bin=88 gives bcd=16'h0088.
- BIN2BCD_AUTO_REFRESH_EN defined, bin=300, then changed to 301 mid-conversion -> first result 16'h0300, next period 16'h0301, done every 15 cycles with start tied 0.
